// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, ALU op codes,
// mux select codes, FSM states and the per-state control word.
package multicycle_control_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    localparam logic [2:0] ALU_FUNCT = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_ADD   = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b011;
    localparam logic [2:0] ALU_OR    = 3'b100;
    localparam logic [2:0] ALU_SLT   = 3'b101;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_EXC    = 2'b11;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_R_EXEC   = 4'd3,
        ST_R_WB     = 4'd4,
        ST_I_EXEC   = 4'd5,
        ST_I_WB     = 4'd6,
        ST_MEM_ADDR = 4'd7,
        ST_MEM_RD   = 4'd8,
        ST_MEM_WB   = 4'd9,
        ST_MEM_WR   = 4'd10,
        ST_BRANCH   = 4'd11,
        ST_JUMP     = 4'd12,
        ST_EXC      = 4'd13
    } state_e;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [2:0] alu_op;
        logic       instr_done;
        logic       bus_err;
    } ctrl_t;

    // ALU operation for immediate-format arithmetic; unlisted opcodes fall back to ADD.
    function automatic logic [2:0] imm_alu_op(input logic [5:0] op);
        case (op)
            OP_ANDI: imm_alu_op = ALU_AND;
            OP_ORI:  imm_alu_op = ALU_OR;
            OP_SLTI: imm_alu_op = ALU_SLT;
            default: imm_alu_op = ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_wait_timer.sv
// Saturating memory-wait counter: cleared on state entry, advanced per stalled
// cycle, flags expiry once TIMEOUT stalled cycles have elapsed.
module mc_wait_timer #(
    parameter int TIMEOUT = 16,
    parameter int TMO_W   = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic inc_i,
    output logic expired_o
);

    localparam logic [TMO_W-1:0] LIMIT = TMO_W'(TIMEOUT);

    logic [TMO_W-1:0] count_q;
    logic [TMO_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != LIMIT)) begin
            count_d = count_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == LIMIT);

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS datapath with memory-timeout abort.
// Define MC_EXCEPTION_EN to trap unknown opcodes into an exception state (adds exc_valid).
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int TMO_W   = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_source,
    output logic [2:0] alu_op,
    output logic       instr_done,
    output logic       bus_err
`ifdef MC_EXCEPTION_EN
    ,
    output logic       exc_valid
`endif
);

    state_e state_q;
    state_e state_d;
    ctrl_t  ctrl;
    logic   expired;
    logic   tmr_clr;
    logic   tmr_inc;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        ctrl    = '0;
        state_d = state_q;
        tmr_inc = 1'b0;
        case (state_q)
            ST_IDLE: state_d = ST_FETCH;

            ST_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_ADD;
                if (mem_ready) begin
                    ctrl.ir_write = 1'b1;
                    ctrl.pc_write = 1'b1;
                    state_d       = ST_DECODE;
                end else if (expired) begin
                    ctrl         = '0;
                    ctrl.bus_err = 1'b1;
                end else begin
                    tmr_inc = 1'b1;
                end
            end

            ST_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH;
                ctrl.alu_op    = ALU_ADD;
                case (opcode)
                    OP_RTYPE:                         state_d = ST_R_EXEC;
                    OP_LW, OP_SW:                     state_d = ST_MEM_ADDR;
                    OP_BEQ:                           state_d = ST_BRANCH;
                    OP_J:                             state_d = ST_JUMP;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = ST_I_EXEC;
                    default: begin
`ifdef MC_EXCEPTION_EN
                        state_d = ST_EXC;
`else
                        ctrl.instr_done = 1'b1;
                        state_d         = ST_FETCH;
`endif
                    end
                endcase
            end

            ST_R_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALU_FUNCT;
                state_d        = ST_R_WB;
            end

            ST_R_WB: begin
                ctrl.reg_dst    = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
                state_d         = ST_FETCH;
            end

            ST_I_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = imm_alu_op(opcode);
                state_d        = ST_I_WB;
            end

            ST_I_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
                state_d         = ST_FETCH;
            end

            ST_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
                state_d        = (opcode == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
            end

            ST_MEM_RD: begin
                ctrl.i_or_d   = 1'b1;
                ctrl.mem_read = 1'b1;
                if (mem_ready) begin
                    state_d = ST_MEM_WB;
                end else if (expired) begin
                    ctrl         = '0;
                    ctrl.bus_err = 1'b1;
                    state_d      = ST_FETCH;
                end else begin
                    tmr_inc = 1'b1;
                end
            end

            ST_MEM_WB: begin
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
                state_d         = ST_FETCH;
            end

            ST_MEM_WR: begin
                ctrl.i_or_d    = 1'b1;
                ctrl.mem_write = 1'b1;
                if (mem_ready) begin
                    ctrl.instr_done = 1'b1;
                    state_d         = ST_FETCH;
                end else if (expired) begin
                    ctrl         = '0;
                    ctrl.bus_err = 1'b1;
                    state_d      = ST_FETCH;
                end else begin
                    tmr_inc = 1'b1;
                end
            end

            ST_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
                ctrl.instr_done    = 1'b1;
                state_d            = ST_FETCH;
            end

            ST_JUMP: begin
                ctrl.pc_write   = 1'b1;
                ctrl.pc_source  = PCSRC_JUMP;
                ctrl.instr_done = 1'b1;
                state_d         = ST_FETCH;
            end

`ifdef MC_EXCEPTION_EN
            ST_EXC: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_EXC;
                state_d        = ST_FETCH;
            end
`endif

            default: state_d = ST_IDLE;
        endcase
    end

    // A timeout abort from FETCH stays in FETCH, so it must restart the count explicitly.
    assign tmr_clr = (state_d != state_q) || ctrl.bus_err;

    mc_wait_timer #(
        .TIMEOUT (TIMEOUT),
        .TMO_W   (TMO_W)
    ) u_wait_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (tmr_clr),
        .inc_i     (tmr_inc),
        .expired_o (expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign i_or_d        = ctrl.i_or_d;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign ir_write      = ctrl.ir_write;
    assign reg_dst       = ctrl.reg_dst;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign reg_write     = ctrl.reg_write;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign pc_source     = ctrl.pc_source;
    assign alu_op        = ctrl.alu_op;
    assign instr_done    = ctrl.instr_done;
    assign bus_err       = ctrl.bus_err;

`ifdef MC_EXCEPTION_EN
    assign exc_valid = (state_q == ST_EXC);
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class, stall,
// timeout and reset cases with hand-computed control words.
module tb_multicycle_control;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, alu_src_a, instr_done, bus_err;
    logic [1:0] alu_src_b, pc_source;
    logic [2:0] alu_op;
`ifdef MC_EXCEPTION_EN
    logic       exc_valid;
`endif

    int checks   = 0;
    int failures = 0;

    multicycle_control #(.TIMEOUT(16), .TMO_W(5)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .pc_source     (pc_source),
        .alu_op        (alu_op),
        .instr_done    (instr_done),
        .bus_err       (bus_err)
`ifdef MC_EXCEPTION_EN
        ,
        .exc_valid     (exc_valid)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control word layout, MSB first.
    logic [18:0] obs;
    assign obs = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                  reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, pc_source,
                  alu_op, instr_done, bus_err};

    localparam logic [18:0] PCW  = 19'd1 << 18;
    localparam logic [18:0] PWC  = 19'd1 << 17;
    localparam logic [18:0] IOD  = 19'd1 << 16;
    localparam logic [18:0] MRD  = 19'd1 << 15;
    localparam logic [18:0] MWR  = 19'd1 << 14;
    localparam logic [18:0] IRW  = 19'd1 << 13;
    localparam logic [18:0] RDST = 19'd1 << 12;
    localparam logic [18:0] M2R  = 19'd1 << 11;
    localparam logic [18:0] RW   = 19'd1 << 10;
    localparam logic [18:0] ALUA = 19'd1 << 9;
    localparam logic [18:0] DONE = 19'd1 << 1;
    localparam logic [18:0] BERR = 19'd1;

    function automatic logic [18:0] srcb(input logic [1:0] v);
        srcb = 19'(v) << 7;
    endfunction
    function automatic logic [18:0] pcs(input logic [1:0] v);
        pcs = 19'(v) << 5;
    endfunction
    function automatic logic [18:0] aop(input logic [2:0] v);
        aop = 19'(v) << 2;
    endfunction

    logic [18:0] fetch_w, decode_w;

    task automatic check(input string tag, input logic [18:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic o, input logic exp);
        checks++;
        assert (o === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, o, exp);
        end
    endtask

    // Apply inputs mid-cycle and let the combinational outputs settle.
    task automatic drive(input logic [5:0] op, input logic rdy);
        @(negedge clk);
        opcode    = op;
        mem_ready = rdy;
        #1;
    endtask

    initial begin
        fetch_w  = MRD | srcb(2'b01) | aop(3'b010);
        decode_w = srcb(2'b11) | aop(3'b010);

        rst_n = 1'b0; opcode = 6'd0; mem_ready = 1'b0;
        #1;
        check("reset_async", 19'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("idle_after_release", 19'd0);
        drive(6'b000000, 1'b0); check("fetch_stall", fetch_w);

        // R-type add
        drive(6'b000000, 1'b1); check("r_fetch", fetch_w | IRW | PCW);
        drive(6'b000000, 1'b1); check("r_decode", decode_w);
        drive(6'b000000, 1'b1); check("r_exec", ALUA | aop(3'b000));
        drive(6'b000000, 1'b1); check("r_wb", RDST | RW | DONE);

        // lw with 3 stall cycles
        drive(6'b100011, 1'b1); check("lw_fetch", fetch_w | IRW | PCW);
        drive(6'b100011, 1'b1); check("lw_decode", decode_w);
        drive(6'b100011, 1'b1); check("lw_addr", ALUA | srcb(2'b10) | aop(3'b010));
        for (int i = 0; i < 3; i++) begin
            drive(6'b100011, 1'b0); check("lw_stall", IOD | MRD);
        end
        drive(6'b100011, 1'b1); check("lw_rd_done", IOD | MRD);
        drive(6'b100011, 1'b1); check("lw_wb", M2R | RW | DONE);

        // beq
        drive(6'b000100, 1'b1); check("beq_fetch", fetch_w | IRW | PCW);
        drive(6'b000100, 1'b0); check("beq_decode", decode_w);
        drive(6'b000100, 1'b0); check("beq_branch", ALUA | aop(3'b001) | PWC | pcs(2'b01) | DONE);

        // ori
        drive(6'b001101, 1'b1); check("ori_fetch", fetch_w | IRW | PCW);
        drive(6'b001101, 1'b0); check("ori_decode", decode_w);
        drive(6'b001101, 1'b0); check("ori_exec", ALUA | srcb(2'b10) | aop(3'b100));
        drive(6'b001101, 1'b0); check("ori_wb", RW | DONE);

        // slti
        drive(6'b001010, 1'b1); check("slti_fetch", fetch_w | IRW | PCW);
        drive(6'b001010, 1'b0); check("slti_decode", decode_w);
        drive(6'b001010, 1'b0); check("slti_exec", ALUA | srcb(2'b10) | aop(3'b101));
        drive(6'b001010, 1'b0); check("slti_wb", RW | DONE);

        // j
        drive(6'b000010, 1'b1); check("j_fetch", fetch_w | IRW | PCW);
        drive(6'b000010, 1'b0); check("j_decode", decode_w);
        drive(6'b000010, 1'b0); check("j_jump", PCW | pcs(2'b10) | DONE);

        // sw that never completes: 16 stalled cycles, then abort
        drive(6'b101011, 1'b1); check("swt_fetch", fetch_w | IRW | PCW);
        drive(6'b101011, 1'b0); check("swt_decode", decode_w);
        drive(6'b101011, 1'b0); check("swt_addr", ALUA | srcb(2'b10) | aop(3'b010));
        for (int i = 0; i < 16; i++) begin
            drive(6'b101011, 1'b0); check("swt_wait", IOD | MWR);
        end
        drive(6'b101011, 1'b0); check("swt_timeout", BERR);
        drive(6'b101011, 1'b0); check("fetch_after_tmo", fetch_w);

        // sw whose ready arrives exactly in the would-be timeout cycle
        drive(6'b101011, 1'b1); check("swl_fetch", fetch_w | IRW | PCW);
        drive(6'b101011, 1'b0); check("swl_decode", decode_w);
        drive(6'b101011, 1'b0); check("swl_addr", ALUA | srcb(2'b10) | aop(3'b010));
        for (int i = 0; i < 16; i++) begin
            drive(6'b101011, 1'b0); check("swl_wait", IOD | MWR);
        end
        drive(6'b101011, 1'b1); check("swl_late_ready", IOD | MWR | DONE);

        // unknown opcode
        drive(6'b111111, 1'b1); check("unk_fetch", fetch_w | IRW | PCW);
`ifdef MC_EXCEPTION_EN
        drive(6'b111111, 1'b0); check("unk_decode", decode_w);
        check_bit("unk_decode_exc", exc_valid, 1'b0);
        drive(6'b111111, 1'b0); check("unk_exc", PCW | pcs(2'b11));
        check_bit("unk_exc_valid", exc_valid, 1'b1);
`else
        drive(6'b111111, 1'b0); check("unk_nop", decode_w | DONE);
`endif
        drive(6'b000000, 1'b0); check("unk_back_fetch", fetch_w);

        // reset in the middle of a load
        drive(6'b100011, 1'b1); check("rst_fetch", fetch_w | IRW | PCW);
        drive(6'b100011, 1'b0); check("rst_decode", decode_w);
        drive(6'b100011, 1'b0); check("rst_addr", ALUA | srcb(2'b10) | aop(3'b010));
        drive(6'b100011, 1'b0); check("rst_rd", IOD | MRD);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("reset_mid", 19'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("idle_after_mid", 19'd0);
        drive(6'b000000, 1'b0); check("fetch_after_mid", fetch_w);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
